// File: rtl/alu_pipe.sv
// alu_pipe: registered, handshaked ALU with an optional iterative multiplier.
//
// Accepts one operation over in_valid/in_ready. Single-cycle opcodes load the
// output register on the acceptance edge. With ALU_MUL_EN defined, opcode 111
// runs a WIDTH-step LSB-first shift-add multiply before loading. Without it,
// opcode 111 is a single-cycle op returning result=0, carry=0. The result and
// flags are held until the sink takes them over out_valid/out_ready.
//
// Optional feature macro: ALU_MUL_EN (iterative unsigned multiply on opcode 111).
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   source presents op/a/b
//   in_ready   block can accept an operation this cycle
//   op         opcode, sampled on acceptance
//   a, b       unsigned operands, sampled on acceptance
//   out_valid  result/flags valid
//   out_ready  sink accepts the result this cycle
//   result     registered result
//   carry      carry / borrow / shifted-out bit / multiply high-half nonzero
//   zero       high when the registered result is zero (low after reset)

module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
`ifdef ALU_MUL_EN
        StMul  = 2'd2,
`endif
        StHold = 2'd1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

`ifdef ALU_MUL_EN
    localparam int unsigned CntW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_step;
`endif

    assign in_ready  = (state_q == StIdle) | ((state_q == StHold) & out_ready);
    assign out_valid = (state_q == StHold);
    assign accept    = in_valid & in_ready;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

    // Single-cycle datapath; opcode 111 yields zero here and is diverted to
    // the multiplier when it is built.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            3'b000: {alu_carry, alu_res} = {1'b0, a} + {1'b0, b};
            3'b001: begin
                alu_res   = a << 1;
                alu_carry = a[WIDTH-1];
            end
            3'b010: alu_res = a & b;
            3'b011: alu_res = a ^ b;
            3'b100: alu_res = WIDTH'(a > b);
            3'b101: begin
                alu_res   = a - b;
                alu_carry = (a < b);
            end
            3'b110: begin
                alu_res   = a >> 1;
                alu_carry = a[0];
            end
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            StIdle, StHold: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (op == 3'b111) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        result_d = alu_res;
                        carry_d  = alu_carry;
                        zero_d   = (alu_res == '0);
                        state_d  = StHold;
                    end
`else
                    result_d = alu_res;
                    carry_d  = alu_carry;
                    zero_d   = (alu_res == '0);
                    state_d  = StHold;
`endif
                end else if (state_q == StHold && out_ready) begin
                    state_d = StIdle;
                end
            end
`ifdef ALU_MUL_EN
            StMul: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                // Last of WIDTH steps: publish the low half, flag a nonzero high half.
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    result_d = acc_step[WIDTH-1:0];
                    carry_d  = |acc_step[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_step[WIDTH-1:0] == '0);
                    state_d  = StHold;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
`ifdef ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule
